// File: rtl/rip_bp_table_scheduler.sv
// Port scheduler for the 2-bit-counter branch predictor RAM: init sweep,
// fetch lookups (highest priority) and FIFO-buffered read-modify-write updates.

package rip_branch_predictor_const;
    localparam int TABLE_DEPTH = 4;
endpackage

module rip_bp_table_scheduler
    import rip_branch_predictor_const::*;
#(
    parameter int INDEX_W    = TABLE_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_busy_o,
    input  logic               pred_req_i,
    input  logic [INDEX_W-1:0] pred_index_i,
    output logic               pred_ready_o,
    output logic               pred_valid_o,
    output logic [1:0]         pred_weight_o,
    input  logic               upd_valid_i,
    output logic               upd_ready_o,
    input  logic [INDEX_W-1:0] upd_index_i,
    input  logic               upd_taken_i,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [INDEX_W-1:0] ram_addr_o,
    output logic [1:0]         ram_wdata_o,
    input  logic [1:0]         ram_rdata_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_READ  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    state_t               state_r, next_state_s;
    logic [INDEX_W-1:0]   sweep_r;
    logic [INDEX_W-1:0]   fifo_idx_r [FIFO_DEPTH];
    logic                 fifo_taken_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic [INDEX_W-1:0]   pend_idx_r;
    logic [1:0]           pend_val_r;
    logic                 pred_valid_r, fwd_sel_r;
    logic [1:0]           fwd_val_r;
    logic                 lookup_s, push_s, pop_s;
    logic                 ram_en_s, ram_we_s;
    logic [INDEX_W-1:0]   ram_addr_s;
    logic [1:0]           ram_wdata_s;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    assign init_busy_o  = (state_r == ST_INIT);
    assign pred_ready_o = !init_busy_o;
    assign upd_ready_o  = (count_r != FULL_CNT);
    assign lookup_s     = !rst && pred_req_i && pred_ready_o;
    assign push_s       = !rst && upd_valid_i && upd_ready_o;

    // Port arbitration and next-state selection; RAM is idle while rst is held.
    always_comb begin
        next_state_s = state_r;
        ram_en_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = {INDEX_W{1'b0}};
        ram_wdata_s  = 2'b00;
        pop_s        = 1'b0;
        if (rst) begin
            next_state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    ram_en_s    = 1'b1;
                    ram_we_s    = 1'b1;
                    ram_addr_s  = sweep_r;
                    ram_wdata_s = 2'b01;
                    if (sweep_r == {INDEX_W{1'b1}}) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (lookup_s) begin
                        ram_en_s   = 1'b1;
                        ram_addr_s = pred_index_i;
                    end else if (count_r != {(PTR_W + 1){1'b0}}) begin
                        ram_en_s     = 1'b1;
                        ram_addr_s   = fifo_idx_r[rd_ptr_r];
                        next_state_s = ST_READ;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (lookup_s) begin
                        ram_en_s   = 1'b1;
                        ram_addr_s = pred_index_i;
                    end else begin
                        ram_en_s = 1'b0;
                    end
                    next_state_s = ST_WRITE;
                end
                ST_WRITE: begin
                    if (lookup_s) begin
                        ram_en_s   = 1'b1;
                        ram_addr_s = pred_index_i;
                    end else begin
                        ram_en_s     = 1'b1;
                        ram_we_s     = 1'b1;
                        ram_addr_s   = pend_idx_r;
                        ram_wdata_s  = pend_val_r;
                        pop_s        = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_INIT;
                end
            endcase
        end
    end

    assign ram_en_o    = ram_en_s;
    assign ram_we_o    = ram_we_s;
    assign ram_addr_o  = ram_addr_s;
    assign ram_wdata_o = ram_wdata_s;

    // State register and init sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            sweep_r <= {INDEX_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_INIT) begin
                sweep_r <= sweep_r + INDEX_W'(1);
            end else begin
                sweep_r <= {INDEX_W{1'b0}};
            end
        end
    end

    // Pending write: the head entry's new counter, captured while its read data is on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_idx_r <= {INDEX_W{1'b0}};
            pend_val_r <= 2'b00;
        end else if (state_r == ST_READ) begin
            pend_idx_r <= fifo_idx_r[rd_ptr_r];
            pend_val_r <= sat_next(ram_rdata_i, fifo_taken_r[rd_ptr_r]);
        end else begin
            pend_idx_r <= pend_idx_r;
            pend_val_r <= pend_val_r;
        end
    end

    // Lookup response tracking; a hit on a stalled pending write is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_r <= 1'b0;
            fwd_sel_r    <= 1'b0;
            fwd_val_r    <= 2'b00;
        end else begin
            pred_valid_r <= lookup_s;
            fwd_sel_r    <= lookup_s && (state_r == ST_WRITE) && (pred_index_i == pend_idx_r);
            fwd_val_r    <= pend_val_r;
        end
    end

    assign pred_valid_o  = pred_valid_r;
    assign pred_weight_o = pred_valid_r ? (fwd_sel_r ? fwd_val_r : ram_rdata_i) : 2'b00;

    // Update FIFO storage; payload needs no reset since pointers qualify it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_idx_r[wr_ptr_r]   <= upd_index_i;
            fifo_taken_r[wr_ptr_r] <= upd_taken_i;
        end
    end

    // Update FIFO pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
